// File: rtl/vec_mac_sequencer_pkg.sv
// Shared definitions for the dot-product issue path: FSM encodings,
// multiplier pipeline depth and default widths shared with the accumulator.
package vec_mac_sequencer_pkg;

  localparam int ELEM_W_DEF    = 12;
  localparam int WORD_SIZE_DEF = 24;
  localparam int LEN_W_DEF     = 8;
  localparam int MUL_LAT       = 2;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/vec_mac_sequencer_if.sv
// Control, operand-stream and accumulator-side signals of the MAC sequencer.
interface vec_mac_sequencer_if
  import vec_mac_sequencer_pkg::*;
#(
  parameter int ELEM_W    = ELEM_W_DEF,
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int LEN_W     = LEN_W_DEF
);

  logic                 start;
  logic [LEN_W-1:0]     vec_len;
  logic [ELEM_W-1:0]    a_data;
  logic [ELEM_W-1:0]    b_data;
  logic                 elem_valid;
  logic                 elem_ready;
  logic [WORD_SIZE-1:0] prod_out;
  logic                 acc_load;
  logic                 acc_clr;
  logic                 busy;
  logic                 done;

  modport master (
    output start, vec_len, a_data, b_data, elem_valid,
    input  elem_ready, prod_out, acc_load, acc_clr, busy, done
  );

  modport slave (
    input  start, vec_len, a_data, b_data, elem_valid,
    output elem_ready, prod_out, acc_load, acc_clr, busy, done
  );

endinterface

// File: rtl/vec_mac_sequencer_mul_pipe2.sv
// mul_pipe2: two-stage registered unsigned multiplier with valid pass-through.
module vec_mac_sequencer_mul_pipe2 #(
  parameter int ELEM_W    = 12,
  parameter int WORD_SIZE = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [ELEM_W-1:0]    a,
  input  logic [ELEM_W-1:0]    b,
  output logic                 out_valid,
  output logic [WORD_SIZE-1:0] prod
);

  localparam int PROD_W = 2 * ELEM_W;

  logic [ELEM_W-1:0]    a_q;
  logic [ELEM_W-1:0]    b_q;
  logic                 v1;
  logic [PROD_W-1:0]    full;
  logic [WORD_SIZE-1:0] word;

  assign full = {{ELEM_W{1'b0}}, a_q} * {{ELEM_W{1'b0}}, b_q};

  // Fit the full product to the accumulator word: zero-extend or keep low bits.
  generate
    if (WORD_SIZE > PROD_W) begin : g_ext
      assign word = {{(WORD_SIZE - PROD_W){1'b0}}, full};
    end else if (WORD_SIZE == PROD_W) begin : g_eq
      assign word = full;
    end else begin : g_trunc
      assign word = full[WORD_SIZE-1:0];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      v1        <= 1'b0;
      out_valid <= 1'b0;
      prod      <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        a_q <= a;
        b_q <= b;
      end
      out_valid <= v1;
      if (v1) prod <= word;
    end
  end

endmodule

// File: rtl/vec_mac_sequencer.sv
// Issue stage of the dot-product path: frames a vector op with clear/done
// strokes and feeds operand pairs through the 2-stage multiplier.
//
//   state | meaning
//   IDLE  | waiting for start; vec_len latched on start
//   CLEAR | one-cycle accumulator clear
//   RUN   | accepting pairs until len have been taken
//   DRAIN | no acceptance; waiting for the last product to load
//   DONE  | one-cycle done pulse, sum is final
module vec_mac_sequencer
  import vec_mac_sequencer_pkg::*;
#(
  parameter int ELEM_W    = ELEM_W_DEF,
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int LEN_W     = LEN_W_DEF
) (
  input logic                clk,
  input logic                rst,
  vec_mac_sequencer_if.slave bus
);

  localparam int             DW         = $clog2(MUL_LAT + 1);
  localparam logic [DW-1:0]  DRAIN_INIT = DW'(MUL_LAT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] remain;
  logic [DW-1:0]    drain_cnt;
  logic             accept;

  // Remaining-element down-counter: no wrap even at the maximum length.
  assign bus.elem_ready = (state == ST_RUN) && (remain != '0);
  assign accept         = bus.elem_valid && bus.elem_ready;
  assign bus.acc_clr    = (state == ST_CLEAR);
  assign bus.busy       = (state != ST_IDLE);
  assign bus.done       = (state == ST_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.start) state_nxt = ST_CLEAR;
      ST_CLEAR: state_nxt = (len_q == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (accept && (remain == LEN_W'(1))) state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_cnt == '0) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      len_q     <= '0;
      remain    <= '0;
      drain_cnt <= '0;
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) && bus.start) len_q <= bus.vec_len;
      if (state == ST_CLEAR) remain <= len_q;
      else if (accept) remain <= remain - LEN_W'(1);
      // Last pair needs MUL_LAT cycles in DRAIN before its load has completed.
      if ((state == ST_RUN) && (state_nxt == ST_DRAIN)) drain_cnt <= DRAIN_INIT;
      else if (drain_cnt != '0) drain_cnt <= drain_cnt - DW'(1);
    end
  end

  vec_mac_sequencer_mul_pipe2 #(
    .ELEM_W    (ELEM_W),
    .WORD_SIZE (WORD_SIZE)
  ) u_mul_pipe2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept),
    .a         (bus.a_data),
    .b         (bus.b_data),
    .out_valid (bus.acc_load),
    .prod      (bus.prod_out)
  );

endmodule

// File: tb/tb_vec_mac_sequencer.sv
// Scoreboard bench for vec_mac_sequencer: vector ops with random data/stalls
// against a dot-product model; a negedge monitor checks every load and done.
module tb_vec_mac_sequencer;
  import vec_mac_sequencer_pkg::*;

  localparam int EW = ELEM_W_DEF;
  localparam int WS = WORD_SIZE_DEF;
  localparam int LW = LEN_W_DEF;

  typedef struct {
    logic [WS-1:0] sum;
    bit            zero;
  } done_exp_t;

  logic clk = 1'b0;
  logic rst;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_busy = 0, n_ready = 0, n_acc = 0, n_load = 0, n_done = 0;
  int clr_cyc = 0, last_acc = 0;

  logic [WS-1:0] prod_q[$];
  int            acc_cyc_q[$];
  done_exp_t     done_q[$];
  logic [WS-1:0] tb_acc = '0;
  logic [EW-1:0] op_a[$];
  logic [EW-1:0] op_b[$];

  vec_mac_sequencer_if #(.ELEM_W(EW), .WORD_SIZE(WS), .LEN_W(LW)) bus ();

  vec_mac_sequencer #(.ELEM_W(EW), .WORD_SIZE(WS), .LEN_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: unsigned product reduced modulo 2^WS.
  function automatic logic [WS-1:0] model_prod(input logic [EW-1:0] a, input logic [EW-1:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    return WS'(p % (64'd1 << WS));
  endfunction

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic fill_random(input int len, input int maxv);
    op_a.delete();
    op_b.delete();
    for (int i = 0; i < len; i++) begin
      op_a.push_back(EW'($urandom_range(1, maxv)));
      op_b.push_back(EW'($urandom_range(1, maxv)));
    end
  endtask

  // Monitor: records handshakes, checks each load against the scoreboard,
  // and checks the accumulated sum and timing at done.
  initial begin : monitor
    logic [WS-1:0] e;
    int            c;
    done_exp_t     d;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) continue;
      if (bus.busy) n_busy++;
      if (bus.elem_ready) n_ready++;
      if (bus.elem_valid && bus.elem_ready) begin
        acc_cyc_q.push_back(cyc);
        last_acc = cyc;
        n_acc++;
      end
      if (bus.acc_clr) begin
        clr_cyc = cyc;
        tb_acc  = '0;
      end
      if (bus.acc_load) begin
        n_load++;
        check("load_has_expect", prod_q.size() != 0, 1'b1);
        if (prod_q.size() != 0) begin
          e = prod_q.pop_front();
          check("prod_out", bus.prod_out, e);
        end
        if (acc_cyc_q.size() != 0) begin
          c = acc_cyc_q.pop_front();
          check("load_latency", cyc - c, 2);
        end
        tb_acc = tb_acc + bus.prod_out;
      end
      if (bus.done) begin
        n_done++;
        check("done_has_expect", done_q.size() != 0, 1'b1);
        if (done_q.size() != 0) begin
          d = done_q.pop_front();
          check("acc_sum", tb_acc, d.sum);
          if (d.zero) check("done_after_clr", cyc - clr_cyc, 1);
          else        check("done_after_last_accept", cyc - last_acc, 3);
        end
      end
    end
  end

  // Runs one vector op from the IDLE (or already-started CLEAR) point.
  task automatic run_op(input int len, input int vmode, input bit issue_start,
                        input bit busy_start, input bit chain, input int chain_len,
                        input int stop_at);
    int idx, ph, budget, load0, done0, acc0, busy0, ready0;
    bit v, poked;
    logic [WS-1:0] s;
    done_exp_t d;
    s = '0;
    for (int i = 0; i < len; i++) begin
      prod_q.push_back(model_prod(op_a[i], op_b[i]));
      s = s + model_prod(op_a[i], op_b[i]);
    end
    d.sum  = s;
    d.zero = (len == 0);
    done_q.push_back(d);
    load0 = n_load; done0 = n_done; acc0 = n_acc; busy0 = n_busy; ready0 = n_ready;

    if (issue_start) begin
      drive_edge();
      bus.start   = 1'b1;
      bus.vec_len = LW'(len);
      drive_edge();
      bus.start   = 1'b0;
      bus.vec_len = LW'($urandom);
      sample();
      check("acc_clr_after_start", bus.acc_clr, 1'b1);
    end

    idx = 0; ph = 0; budget = 0; poked = 1'b0;
    while (idx < len && idx != stop_at && budget < 5000) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = (ph % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      bus.a_data     = op_a[idx];
      bus.b_data     = op_b[idx];
      bus.elem_valid = v;
      if (busy_start && !poked && idx == 2) begin
        bus.start   = 1'b1;
        bus.vec_len = LW'(9);
        poked       = 1'b1;
      end
      sample();
      if (v && bus.elem_ready) idx++;
      ph++;
      budget++;
      drive_edge();
      bus.start = 1'b0;
    end
    if (idx == stop_at) return;
    check("elements_fed", idx, len);

    bus.elem_valid = 1'b1;
    budget = 0;
    while (n_done == done0 && budget < 64) begin
      if (chain) begin
        bus.start   = 1'b1;
        bus.vec_len = LW'(chain_len);
      end
      sample();
      budget++;
      if (n_done == done0) drive_edge();
    end
    check("single_done", n_done - done0, 1);

    if (chain) begin
      drive_edge();
      sample();
      check("start_in_done_ignored", bus.busy, 1'b0);
      drive_edge();
      bus.start = 1'b0;
      sample();
      check("acc_clr_after_idle_start", bus.acc_clr, 1'b1);
    end else begin
      drive_edge();
      sample();
      check("idle_after_done", bus.busy, 1'b0);
    end
    check("load_count", n_load - load0, len);
    check("accept_count", n_acc - acc0, len);
    if (len == 0) begin
      check("zero_len_busy_cycles", n_busy - busy0, 2);
      check("zero_len_ready_cycles", n_ready - ready0, 0);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int len;
    bus.start = 1'b0; bus.vec_len = '0; bus.a_data = '0; bus.b_data = '0; bus.elem_valid = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_elem_ready", bus.elem_ready, 1'b0);
    check("rst_prod_out", bus.prod_out, '0);
    check("rst_acc_load", bus.acc_load, 1'b0);
    check("rst_acc_clr", bus.acc_clr, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    repeat (2) @(posedge clk);
    sample();
    rst = 1'b0;

    op_a = '{12'd1, 12'd2, 12'd3};
    op_b = '{12'd4, 12'd5, 12'd6};
    run_op(3, 0, 1'b1, 1'b0, 1'b0, 0, -1);

    op_a = '{12'd2, 12'd2, 12'd2, 12'd2};
    op_b = '{12'd3, 12'd3, 12'd3, 12'd3};
    run_op(4, 1, 1'b1, 1'b0, 1'b0, 0, -1);

    op_a.delete();
    op_b.delete();
    run_op(0, 0, 1'b1, 1'b0, 1'b0, 0, -1);

    op_a = '{12'd4095, 12'd4095};
    op_b = '{12'd4095, 12'd4095};
    run_op(2, 0, 1'b1, 1'b0, 1'b0, 0, -1);

    fill_random(5, 4095);
    run_op(5, 2, 1'b1, 1'b1, 1'b0, 0, -1);

    fill_random(4, 4095);
    run_op(4, 2, 1'b1, 1'b0, 1'b1, 3, -1);
    fill_random(3, 4095);
    run_op(3, 0, 1'b0, 1'b0, 1'b0, 0, -1);

    for (int k = 0; k < 6; k++) begin
      len = $urandom_range(1, 16);
      fill_random(len, 4095);
      run_op(len, 2, 1'b1, 1'b0, 1'b0, 0, -1);
    end

    fill_random(255, 4095);
    run_op(255, 2, 1'b1, 1'b0, 1'b0, 0, -1);

    fill_random(5, 4095);
    run_op(5, 0, 1'b1, 1'b0, 1'b0, 0, 2);
    #2 rst = 1'b1;
    #1;
    check("midrun_rst_elem_ready", bus.elem_ready, 1'b0);
    check("midrun_rst_prod_out", bus.prod_out, '0);
    check("midrun_rst_acc_load", bus.acc_load, 1'b0);
    check("midrun_rst_acc_clr", bus.acc_clr, 1'b0);
    check("midrun_rst_busy", bus.busy, 1'b0);
    check("midrun_rst_done", bus.done, 1'b0);
    prod_q.delete();
    acc_cyc_q.delete();
    done_q.delete();
    bus.elem_valid = 1'b0;
    drive_edge();
    drive_edge();
    sample();
    rst = 1'b0;
    sample();
    check("idle_after_reset", bus.busy, 1'b0);
    check("no_ready_after_reset", bus.elem_ready, 1'b0);

    op_a = '{12'd7};
    op_b = '{12'd8};
    run_op(1, 0, 1'b1, 1'b0, 1'b0, 0, -1);

    repeat (4) drive_edge();
    check("prod_queue_drained", prod_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);
    check("accept_queue_drained", acc_cyc_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vec_mac_sequencer.md
Name: vec_mac_sequencer

Overview:
Upstream issue stage of the vector machine's dot-product path. Accepts a stream of operand pairs (a_i, b_i) through a valid/ready handshake and multiplies each pair in a 2-stage pipeline. Presents each product to the downstream accumulator with a one-cycle load strobe. Frames each vector operation with an accumulator-clear pulse at the start and a done pulse once the final product has been absorbed.

Parameters:
ELEM_W, 12, width of each unsigned vector element.
WORD_SIZE, 24, width of the product and accumulator word.
LEN_W, 8, width of the vector-length field; max length 2^LEN_W-1.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset, asynchronous, active-high.
start  in  1  one-cycle request to begin a vector op; ignored unless the FSM is in IDLE.
vec_len  in  LEN_W  element count; sampled only on an accepted start.
a_data  in  ELEM_W  operand A element.
b_data  in  ELEM_W  operand B element.
elem_valid  in  1  source has a valid a/b pair.
elem_ready  out  1  sequencer accepts a pair this cycle.
prod_out  out  WORD_SIZE  registered product to the accumulator data input.
acc_load  out  1  prod_out valid; accumulator adds it on this edge.
acc_clr  out  1  one-cycle synchronous clear request to the accumulator.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse; accumulator sum is final in this cycle.

Behaviour:
- Reset (async, any time, including mid-operation):
  - FSM goes to IDLE; element counter, latched length, pipeline valid bits and operand/product registers are cleared.
  - All outputs are 0: elem_ready, prod_out, acc_load, acc_clr, busy, done.
- FSM states and transitions:
  - IDLE: start=1 latches vec_len -> CLEAR.
  - CLEAR: acc_clr=1 for exactly one cycle. If the latched length is 0 -> DONE, otherwise -> RUN.
  - RUN: elem_ready = (count < len). A pair is accepted when elem_valid && elem_ready; each acceptance increments count. The edge that accepts element number len goes -> DRAIN.
  - DRAIN: elem_ready=0. Stays until the final product's acc_load cycle has completed -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Pipeline:
  - Stage 1 registers a, b and v1 on acceptance.
  - Stage 2 registers the product and v2; acc_load = v2.
  - A pair accepted in cycle t produces acc_load=1 with its product on prod_out in cycle t+2.
  - Throughput is one pair per cycle; bubbles propagate as acc_load=0.
  - prod_out holds its last value when acc_load=0.
- done timing: done=1 in cycle t+3, where t is the cycle the final pair was accepted. The accumulator has already registered the last product by then.
- Arithmetic:
  - Unsigned ELEM_W x ELEM_W product, 2*ELEM_W bits.
  - Zero-extended to WORD_SIZE if wider; low WORD_SIZE bits kept if narrower.
  - No saturation.
- Boundaries:
  - start asserted while busy is ignored; vec_len is not resampled.
  - elem_valid during IDLE, CLEAR, DRAIN or DONE is not accepted.
  - Source stall (elem_valid=0) in RUN: hold count, pipeline drains normally.
  - vec_len=0: CLEAR then DONE; acc_load is never asserted.
  - vec_len=2^LEN_W-1: counter must not wrap before the comparison.
  - start in the same cycle as DONE is ignored; it is honoured from the following IDLE cycle.

Decomposition:
- Shared package: FSM state encodings (IDLE, CLEAR, RUN, DRAIN, DONE), the pipeline depth constant MUL_LAT=2, and default width constants shared with the accumulator (WORD_SIZE=24).
- One sub-module, mul_pipe2. It contains the 2-stage registered unsigned multiplier with valid pass-through, async reset and ELEM_W/WORD_SIZE parameters.
- The sequencer holds the FSM, the counter and the handshake logic.

Test Plan:
- Basic dot product: len=3, a={1,2,3}, b={4,5,6}, elem_valid held high.
  - acc_clr pulses the cycle after start.
  - acc_load is high 3 consecutive cycles with prod_out=4, 10, 18.
  - done one cycle later; a connected accumulator reads 32.
- Backpressure: len=4, elem_valid toggles 1,0,1,0,... with a={2,2,2,2}, b={3,3,3,3}.
  - Exactly 4 acc_load pulses with value 6, each 2 cycles after its acceptance.
  - done 3 cycles after the 4th accept; accumulator reads 24.
- Zero length: start with vec_len=0.
  - acc_clr pulse, then done the next cycle.
  - elem_ready and acc_load never assert; busy high for 2 cycles.
- Max operands: len=2, a=b=4095 for both elements.
  - prod_out=0xFFE001 twice; accumulator wraps to 0xFFC002.
- Start while busy: second start mid-RUN with vec_len=9 during a len=5 operation.
  - Exactly 5 acc_load pulses; a single done.
- Reset mid-RUN: assert rst after 2 of 5 elements.
  - All outputs 0 immediately (asynchronously).
  - After release, FSM is in IDLE; a new len=1 op (a=7, b=8) yields prod_out=56 and done.
